// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The slave modport is the adder side and the master modport is the producer/consumer side.
interface pipelined_cla_adder_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES slice per stage,
// GROUP-bit lookahead groups rippling inside a slice, carry registered between slices.
module pipelined_cla_adder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned GROUP  = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   input logic                   flush,
   pipelined_cla_adder_if.slave  bus
);
   localparam int unsigned SW = WIDTH / STAGES;
   localparam int unsigned NG = SW / GROUP;
   localparam int unsigned NR = (STAGES > 1) ? STAGES - 1 : 1;

   if (STAGES < 1 || (WIDTH % (STAGES * GROUP)) != 0) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH must be divisible by STAGES*GROUP, STAGES >= 1");
   end

   // Returns {carry into slice MSB, slice carry-out, slice sum}.
   function automatic logic [SW+1:0] f_slice(input logic [SW-1:0] i_x,
                                             input logic [SW-1:0] i_y,
                                             input logic          i_c);
      logic [SW-1:0] w_g;
      logic [SW-1:0] w_p;
      logic [SW:0]   w_cy;
      logic          w_t;
      logic          w_pp;
      w_g     = i_x & i_y;
      w_p     = i_x | i_y;
      w_cy    = '0;
      w_cy[0] = i_c;
      for (int g = 0; g < int'(NG); g++) begin
         for (int i = 0; i < int'(GROUP); i++) begin
            // Every carry in the group is expanded from the group carry-in alone.
            w_t = w_cy[g*GROUP];
            for (int j = 0; j <= i; j++) w_t = w_t & w_p[g*GROUP+j];
            for (int j = 0; j <= i; j++) begin
               w_pp = w_g[g*GROUP+j];
               for (int m = j + 1; m <= i; m++) w_pp = w_pp & w_p[g*GROUP+m];
               w_t = w_t | w_pp;
            end
            w_cy[g*GROUP+i+1] = w_t;
         end
      end
      return {w_cy[SW-1], w_cy[SW], i_x ^ i_y ^ w_cy[SW-1:0]};
   endfunction

   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_c;
   logic [WIDTH-1:0]  r_sum [STAGES];
   logic [WIDTH-1:0]  r_a   [NR];
   logic [WIDTH-1:0]  r_b   [NR];
   logic              r_ovf;

   logic [STAGES-1:0] w_adv;
   logic [STAGES-1:0] w_v_src;
   logic [STAGES-1:0] w_c_src;
   logic [WIDTH-1:0]  w_a_src [STAGES];
   logic [WIDTH-1:0]  w_b_src [STAGES];
   logic [WIDTH-1:0]  w_s_src [STAGES];
   logic [WIDTH-1:0]  w_s_nx  [STAGES];
   logic [SW+1:0]     w_res   [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_src_in
         assign w_v_src[k] = bus.in_valid;
         assign w_a_src[k] = bus.a;
         assign w_b_src[k] = bus.b ^ {WIDTH{bus.sub}};
         assign w_c_src[k] = bus.cin ^ bus.sub;
         assign w_s_src[k] = '0;
      end else begin : g_src_reg
         assign w_v_src[k] = r_vld[k-1];
         assign w_a_src[k] = r_a[k-1];
         assign w_b_src[k] = r_b[k-1];
         assign w_c_src[k] = r_c[k-1];
         assign w_s_src[k] = r_sum[k-1];
      end

      if (k == STAGES - 1) begin : g_adv_last
         assign w_adv[k] = !r_vld[k] || bus.out_ready;
      end else begin : g_adv_mid
         assign w_adv[k] = !r_vld[k] || w_adv[k+1];
      end

      assign w_res[k] = f_slice(w_a_src[k][k*SW +: SW], w_b_src[k][k*SW +: SW], w_c_src[k]);

      always_comb begin
         w_s_nx[k]              = w_s_src[k];
         w_s_nx[k][k*SW +: SW]  = w_res[k][SW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         for (int k = 0; k < int'(STAGES); k++) r_sum[k] <= '0;
         for (int k = 0; k < int'(NR); k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
         end
      end else if (flush) begin
         r_vld <= '0;
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (w_adv[k]) begin
               r_vld[k] <= w_v_src[k];
               r_c[k]   <= w_res[k][SW];
               r_sum[k] <= w_s_nx[k];
            end
         end
         for (int k = 0; k < int'(NR); k++) begin
            if (w_adv[k]) begin
               r_a[k] <= w_a_src[k];
               r_b[k] <= w_b_src[k];
            end
         end
         if (w_adv[STAGES-1]) r_ovf <= w_res[STAGES-1][SW+1] ^ w_res[STAGES-1][SW];
      end
   end

   assign bus.in_ready  = w_adv[0];
   assign bus.out_valid = r_vld[STAGES-1];
   assign bus.sum       = r_sum[STAGES-1];
   assign bus.cout      = r_c[STAGES-1];
   assign bus.ovf       = r_ovf;
   assign bus.zero      = (r_sum[STAGES-1] == '0);
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=32, STAGES=2, GROUP=4):
// directed corner cases, stall/flush/reset scenarios and a randomized stream.
module tb_pipelined_cla_adder;
   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   n_chk  = 0;
   int   n_pass = 0;
   res_t q[$];
   logic held_vld = 1'b0;
   logic [31:0] held_sum;
   logic held_cout, held_ovf;
   logic saw_low;

   pipelined_cla_adder_if #(.WIDTH(32)) bus ();

   pipelined_cla_adder #(
      .WIDTH (32),
      .STAGES(2),
      .GROUP (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flush),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic res_t ref_add(input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub);
      res_t        r;
      logic [31:0] be;
      logic [32:0] t;
      be     = sub ? ~b : b;
      t      = {1'b0, a} + {1'b0, be} + {32'd0, cin ^ sub};
      r.sum  = t[31:0];
      r.cout = t[32];
      r.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
      return r;
   endfunction

   // Called just after a negedge; drives one cycle, scores the upcoming edge, ends at next negedge.
   task automatic step(input logic v, input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic c_i, input logic s_i, input logic ordy, input logic fl,
                       output logic acc);
      res_t e;
      bus.in_valid  = v;
      bus.a         = a_i;
      bus.b         = b_i;
      bus.cin       = c_i;
      bus.sub       = s_i;
      bus.out_ready = ordy;
      flush         = fl;
      #1;
      acc = 1'b0;
      if (held_vld) begin
         chk("stall_sum", bus.sum, held_sum);
         chk("stall_cout", bus.cout, held_cout);
         chk("stall_ovf", bus.ovf, held_ovf);
      end
      if (!rst_n || fl) begin
         q.delete();
      end else begin
         if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               chk("sum", bus.sum, e.sum);
               chk("cout", bus.cout, e.cout);
               chk("ovf", bus.ovf, e.ovf);
               chk("zero", bus.zero, e.sum == 32'd0);
            end
         end
         if (v && bus.in_ready) begin
            q.push_back(ref_add(a_i, b_i, c_i, s_i));
            acc = 1'b1;
         end
      end
      held_vld  = rst_n && !fl && bus.out_valid && !ordy;
      held_sum  = bus.sum;
      held_cout = bus.cout;
      held_ovf  = bus.ovf;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy, 1'b0, acc);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || bus.out_valid) && n < 20) begin
         idle(1'b1);
         n++;
      end
      chk("drain_empty", q.size(), 0);
      chk("drain_outv", bus.out_valid, 0);
   endtask

   // Single operation into an empty pipe, with the two-edge latency checked.
   task automatic directed(input logic [31:0] a_i, input logic [31:0] b_i,
                           input logic c_i, input logic s_i);
      logic acc;
      drain();
      step(1'b1, a_i, b_i, c_i, s_i, 1'b1, 1'b0, acc);
      chk("dir_accept", acc, 1);
      chk("lat_early", bus.out_valid, 0);
      idle(1'b1);
      chk("lat_valid", bus.out_valid, 1);
      idle(1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   i;
      int   c;
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      @(negedge clk);
      idle(1'b0);
      idle(1'b0);
      rst_n = 1'b1;
      chk("rst_outv", bus.out_valid, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_cout", bus.cout, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_zero", bus.zero, 1);
      chk("rst_inrdy", bus.in_ready, 1);

      directed(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      directed(32'h0000_FFFF, 32'd1, 1'b0, 1'b0);
      directed(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      directed(32'd5, 32'd5, 1'b0, 1'b1);
      directed(32'd0, 32'd1, 1'b0, 1'b1);
      directed(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      directed(32'd10, 32'd3, 1'b1, 1'b1);
      drain();

      // Back-to-back stream with a three-cycle consumer stall.
      i = 0;
      c = 0;
      saw_low = 1'b0;
      while (i < 8 && c < 40) begin
         step(1'b1, i, 2 * i, 1'b0, 1'b0, !(c >= 3 && c <= 5), 1'b0, acc);
         if (!acc) saw_low = 1'b1;
         if (acc) i++;
         c++;
      end
      chk("stream_all_in", i, 8);
      chk("stream_inrdy_low", saw_low, 1);
      drain();

      // Flush with two in flight, an offered operation dropped at the flush edge.
      step(1'b1, 32'd100, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'd200, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'd300, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      chk("flush_outv", bus.out_valid, 0);
      chk("flush_inrdy", bus.in_ready, 1);
      directed(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      drain();

      // Reset mid-stream.
      step(1'b1, 32'd7, 32'd8, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      step(1'b1, 32'd9, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      rst_n = 1'b0;
      step(1'b1, 32'd11, 32'd12, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      rst_n = 1'b1;
      chk("mrst_outv", bus.out_valid, 0);
      chk("mrst_sum", bus.sum, 0);
      chk("mrst_zero", bus.zero, 1);
      chk("mrst_inrdy", bus.in_ready, 1);
      directed(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);

      // Randomized stream with random back-pressure and operand corners.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ra, rb;
         ra = $urandom();
         rb = $urandom();
         if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
         if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
         if ($urandom_range(0, 9) == 0) rb = ra;
         step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, 1'b0, acc);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake and stall support.
- Splits a WIDTH-bit operation into STAGES slices. Each slice is built from GROUP-bit lookahead groups with ripple between groups.
- The carry is registered between slices, giving a throughput of one operation per cycle and a latency of STAGES cycles.
- Serves the EX stage for multi-cycle arithmetic and as the address/offset adder where timing closure needs pipelining.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STAGES, 2, number of pipeline slices; also the latency in cycles. Must be ≥1.
- GROUP, 4, lookahead group width. WIDTH must be divisible by STAGES*GROUP; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  operands valid
- in_ready  output  1  adder accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, or borrow-in when sub=1
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry-out (in sub mode, 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  sum == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled only on the rising clk edge.
- Reset state: all stage valid bits, data registers and carry registers = 0. Consequently out_valid=0, sum=0, cout=0, ovf=0, zero=1 (derived from sum=0), and in_ready=1 in the first cycle after reset.
- Priority per edge: rst_n low > flush > normal advance.
- Operand conditioning at accept:
  - b_eff = b XOR {WIDTH{sub}}.
  - c_eff = cin XOR sub. So sub=1, cin=0 gives a−b; sub=1, cin=1 gives a−b−1.
- Slice arithmetic: slice k (0 = LSB) covers bits [(k+1)*W/S−1 : k*W/S].
  - Per group: G=a&b, P=a|b, sum bit = a^b^c.
  - Group carry-out = G3|P3G2|P3P2G1|P3P2P1G0|P3P2P1P0·cin, fully lookahead within the group.
  - Groups ripple within a slice.
- Pipeline data flow:
  - Stage 0 computes slice 0 from the accepted operands and registers: slice-0 sum, carry-out, and the unprocessed upper operand bits.
  - Stage k computes slice k from its stored operands and the registered carry, then forwards the partial sum.
  - The final stage register holds the full sum, cout, and ovf = carry into MSB XOR carry out of MSB.
  - zero is combinational from the final sum register.
- Handshake:
  - Stage k advances when its valid is 0 or stage k+1 advances; the last stage advances when out_valid=0 or out_ready=1.
  - in_ready = advance of stage 0. This is combinational from out_ready; no other combinational path exists.
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - A stalled stage holds all its registers unchanged.
  - A full pipeline with out_ready=1 accepts and retires simultaneously, sustaining one result per cycle.
- Latency: an operation accepted at edge n presents out_valid=1 after edge n+STAGES−1 (visible in the cycle following edge n+STAGES−1), provided no stall occurs.
- flush: clears every valid bit at the edge; data registers are don't-care. An operation offered at the same edge is dropped, and in_ready is not forced low.
- Ordering: results leave strictly in acceptance order, with no drops or duplicates under any out_ready pattern.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/zero stay stable.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only on cout.

Test Plan:
- WIDTH=32, STAGES=2: a=0x7FFFFFFF, b=1, sub=0, cin=0 → sum=0x80000000, cout=0, ovf=1, zero=0. out_valid rises two edges after accept.
- a=0x0000FFFF, b=1, add → sum=0x00010000, cout=0. This checks the carry crossing the slice-0/slice-1 register boundary. Also a=0xFFFFFFFF, b=1 → sum=0, cout=1, zero=1, ovf=0.
- sub=1: a=5, b=5, cin=0 → sum=0, cout=1, zero=1. a=0, b=1 → sum=0xFFFFFFFF, cout=0, ovf=0. a=0x80000000, b=1 → sum=0x7FFFFFFF, ovf=1. a=10, b=3, cin=1 → sum=6.
- Stream 8 back-to-back operations (i + 2i, i=0..7) with out_ready held low for cycles 3–5 → in_ready drops once both stages are full, and all 8 results 3i emerge in order with none lost or duplicated.
- Two operations in flight, flush=1 for one cycle → out_valid=0 on the next cycle, neither result ever appears, and a new operation accepted afterwards returns correctly.
- rst_n low for one edge mid-stream → out_valid=0, sum=0, zero=1, in_ready=1, and the first post-reset operation yields its correct result at latency 2.
